// File: rtl/march_bist.sv
// March C- memory BIST engine: runs E0..E5 over every address for NUM_BG data backgrounds.
// Define MARCH_BIST_DIAG_EN to build first-fail capture (fail_addr/elem/bg) and the miscompare counter.
module march_bist #(
    parameter int ADR_SIZE  = 4,
    parameter int DATA_SIZE = 8,
    parameter int NUM_BG    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic [ADR_SIZE-1:0]  mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic                 done,
    output logic                 status,
    output logic [ADR_SIZE-1:0]  fail_addr,
    output logic [2:0]           fail_elem,
    output logic [1:0]           fail_bg,
    output logic [15:0]          fail_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADR_SIZE-1:0] ADDR_MAX = {ADR_SIZE{1'b1}};
    localparam logic [1:0]          LAST_BG  = 2'(NUM_BG - 1);

    state_t               r_state;
    logic [2:0]           r_elem;
    logic [ADR_SIZE-1:0]  r_addr;
    logic [1:0]           r_bg;
    logic                 r_phase;      // 0: first op at this address, 1: the write of a read/write pair
    logic                 r_done;
    logic                 r_status;
    logic                 r_cmp_valid;
    logic [DATA_SIZE-1:0] r_exp;

    logic [DATA_SIZE-1:0] w_bg_word;
    logic                 w_run;
    logic                 w_two_op;
    logic                 w_is_write;
    logic                 w_down;
    logic                 w_addr_last;
    logic                 w_addr_done;
    logic                 w_run_last;
    logic                 w_wr_inv;
    logic                 w_rd_inv;
    logic [2:0]           w_next_elem;
    logic [ADR_SIZE-1:0]  w_next_start;
    logic                 w_start_run;
    logic                 w_miscompare;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_bg_word = '0;
        for (int i = 0; i < DATA_SIZE; i++) begin
            case (r_bg)
                2'd1:    w_bg_word[i] = ((i % 2) == 0);
                2'd2:    w_bg_word[i] = (((i / 2) % 2) == 0);
                default: w_bg_word[i] = 1'b0;
            endcase
        end
    end

    assign w_run        = (r_state == S_RUN);
    assign w_two_op     = (r_elem != 3'd0) && (r_elem != 3'd5);
    assign w_is_write   = (r_elem == 3'd0) || (w_two_op && r_phase);
    assign w_down       = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_addr_last  = w_down ? (r_addr == '0) : (r_addr == ADDR_MAX);
    assign w_addr_done  = !w_two_op || r_phase;
    assign w_run_last   = w_addr_done && w_addr_last && (r_elem == 3'd5) && (r_bg == LAST_BG);
    assign w_wr_inv     = (r_elem == 3'd1) || (r_elem == 3'd3);
    assign w_rd_inv     = (r_elem == 3'd2) || (r_elem == 3'd4);
    assign w_next_elem  = (r_elem == 3'd5) ? 3'd0 : 3'(r_elem + 3'd1);
    assign w_next_start = ((w_next_elem == 3'd3) || (w_next_elem == 3'd4)) ? ADDR_MAX : '0;
    assign w_start_run  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_miscompare = r_cmp_valid && (mem_rdata != r_exp);

    // Strobes decode straight from the state register so an async reset drops them at once.
    assign mem_we    = w_run && w_is_write;
    assign mem_re    = w_run && !w_is_write;
    assign mem_addr  = w_run ? r_addr : '0;
    assign mem_wdata = mem_we ? (w_wr_inv ? ~w_bg_word : w_bg_word) : '0;
    assign done      = r_done;
    assign status    = r_status;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_elem      <= '0;
            r_addr      <= '0;
            r_bg        <= '0;
            r_phase     <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_exp       <= '0;
        end else begin
            r_cmp_valid <= mem_re;
            if (mem_re) r_exp <= w_rd_inv ? ~w_bg_word : w_bg_word;
            if (w_miscompare) r_status <= 1'b1;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_done   <= 1'b0;
                        r_status <= 1'b0;
                        r_elem   <= '0;
                        r_addr   <= '0;
                        r_bg     <= '0;
                        r_phase  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!w_addr_done) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (w_addr_last) begin
                            r_elem <= w_next_elem;
                            r_addr <= w_next_start;
                            if (r_elem == 3'd5) r_bg <= w_run_last ? 2'd0 : 2'(r_bg + 2'd1);
                            if (w_run_last) r_state <= S_DRAIN;
                        end else begin
                            r_addr <= w_down ? ADR_SIZE'(r_addr - 1'b1) : ADR_SIZE'(r_addr + 1'b1);
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MARCH_BIST_DIAG_EN
    logic [ADR_SIZE-1:0] r_cmp_addr;
    logic [2:0]          r_cmp_elem;
    logic [1:0]          r_cmp_bg;
    logic [ADR_SIZE-1:0] r_fail_addr;
    logic [2:0]          r_fail_elem;
    logic [1:0]          r_fail_bg;
    logic [15:0]         r_fail_count;

    // Context of each read travels alongside its expected word; only the first miscompare is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmp_addr   <= '0;
            r_cmp_elem   <= '0;
            r_cmp_bg     <= '0;
            r_fail_addr  <= '0;
            r_fail_elem  <= '0;
            r_fail_bg    <= '0;
            r_fail_count <= '0;
        end else begin
            if (mem_re) begin
                r_cmp_addr <= r_addr;
                r_cmp_elem <= r_elem;
                r_cmp_bg   <= r_bg;
            end
            if (w_start_run) begin
                r_fail_addr  <= '0;
                r_fail_elem  <= '0;
                r_fail_bg    <= '0;
                r_fail_count <= '0;
            end else if (w_miscompare) begin
                if (!r_status) begin
                    r_fail_addr <= r_cmp_addr;
                    r_fail_elem <= r_cmp_elem;
                    r_fail_bg   <= r_cmp_bg;
                end
                if (r_fail_count != 16'hFFFF) r_fail_count <= r_fail_count + 16'd1;
            end
        end
    end

    assign fail_addr  = r_fail_addr;
    assign fail_elem  = r_fail_elem;
    assign fail_bg    = r_fail_bg;
    assign fail_count = r_fail_count;
`else
    assign fail_addr  = '0;
    assign fail_elem  = '0;
    assign fail_bg    = '0;
    assign fail_count = '0;
`endif

endmodule

// File: tb/tb_march_bist.sv
// Self-checking bench for march_bist: behavioural SRAM with an injectable stuck-at cell and
// a March C- reference model that expands the element table into an expected op list.
module tb_march_bist;

    localparam int ADR   = 4;
    localparam int DW    = 8;
    localparam int NBG   = 2;
    localparam int DEPTH = 16;
    localparam int N     = NBG * 10 * DEPTH;

    localparam logic [7:0] BG_WORD [3] = '{8'h00, 8'h55, 8'h33};
    localparam int         N_OPS   [6] = '{1, 2, 2, 2, 2, 1};
    localparam bit         DOWN    [6] = '{0, 0, 0, 1, 1, 0};
    localparam bit         INV0    [6] = '{0, 0, 1, 0, 1, 0};

    typedef struct packed {
        logic       we;
        logic       re;
        logic [3:0] addr;
        logic [7:0] wdata;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  mem_rdata;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        done;
    logic        status;
    logic [3:0]  fail_addr;
    logic [2:0]  fail_elem;
    logic [1:0]  fail_bg;
    logic [15:0] fail_count;

    int checks   = 0;
    int failures = 0;

    bit f_en;
    int f_addr;
    int f_bit;
    bit f_val;

    logic [7:0] sram [DEPTH];
    op_t        exp_q [$];
    int         m_count, m_addr, m_elem, m_bg;

    always #5 clk = ~clk;

    march_bist #(.ADR_SIZE(ADR), .DATA_SIZE(DW), .NUM_BG(NBG)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .done       (done),
        .status     (status),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_bg    (fail_bg),
        .fail_count (fail_count)
    );

    function automatic logic [7:0] faulty(input logic [7:0] d, input int a);
        logic [7:0] r;
        r = d;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= faulty(sram[mem_addr], int'(mem_addr));
    end

    // Expand the March C- element table into the expected op list and predict the miscompares.
    function automatic void build_model();
        logic [7:0] mm [DEPTH];
        logic [7:0] word, rd;
        int         a;
        bit         inv, is_w;
        op_t        op;
        exp_q.delete();
        m_count = 0; m_addr = 0; m_elem = 0; m_bg = 0;
        for (int bg = 0; bg < NBG; bg++)
            for (int e = 0; e < 6; e++)
                for (int k = 0; k < DEPTH; k++)
                    for (int o = 0; o < N_OPS[e]; o++) begin
                        a     = DOWN[e] ? DEPTH - 1 - k : k;
                        inv   = (o == 0) ? INV0[e] : !INV0[e];
                        word  = inv ? ~BG_WORD[bg] : BG_WORD[bg];
                        is_w  = (e == 0) || (o == 1);
                        op.we = is_w;
                        op.re = !is_w;
                        op.addr  = 4'(a);
                        op.wdata = is_w ? word : 8'h00;
                        exp_q.push_back(op);
                        if (is_w) begin
                            mm[a] = word;
                        end else begin
                            rd = faulty(mm[a], a);
                            if (rd !== word) begin
                                if (m_count == 0) begin
                                    m_addr = a; m_elem = e; m_bg = bg;
                                end
                                m_count++;
                            end
                        end
                    end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input string tag, input int repulse_at, input int abort_at);
        build_model();
        repeat ($urandom_range(1, 4)) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                check({tag, "_entry_done"}, 32'(done), 32'd0);
                check({tag, "_entry_status"}, 32'(status), 32'd0);
                check({tag, "_entry_fail"}, {fail_addr, fail_elem, fail_bg, fail_count}, 32'd0);
                check({tag, "_first_write"}, {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd0, 8'h00});
            end
            if (i == N / NBG)
                check({tag, "_bg1_e0_write"}, {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd0, 8'h55});
            check($sformatf("%s_op%0d", tag, i),
                  32'({mem_we, mem_re, mem_addr, (mem_we ? mem_wdata : 8'h00)}), 32'(exp_q[i]));
            if (i == repulse_at) start = 1'b1;
            if (i == repulse_at + 1) start = 1'b0;
            if (i == abort_at) begin
                #1 rst = 1'b0;
                #1;
                check({tag, "_abort_strobes"}, {mem_we, mem_re, mem_addr, mem_wdata}, 32'd0);
                check({tag, "_abort_flags"}, {done, status, fail_addr, fail_elem, fail_bg, fail_count}, 32'd0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        check({tag, "_drain_done"}, 32'(done), 32'd0);
        check({tag, "_drain_strobes"}, {mem_we, mem_re}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_status"}, 32'(status), 32'(m_count > 0));
`ifdef MARCH_BIST_DIAG_EN
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'(m_addr));
        check({tag, "_fail_elem"}, 32'(fail_elem), 32'(m_elem));
        check({tag, "_fail_bg"}, 32'(fail_bg), 32'(m_bg));
        check({tag, "_fail_count"}, 32'(fail_count), 32'(m_count));
`else
        check({tag, "_fail_regs"}, {fail_addr, fail_elem, fail_bg, fail_count}, 32'd0);
`endif
        repeat (3) @(negedge clk);
        check({tag, "_done_hold"}, 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        f_en = 1'b0; f_addr = 0; f_bit = 0; f_val = 1'b0;
        #2;
        check("reset_done_status", {done, status}, 32'd0);
        check("reset_strobes", {mem_we, mem_re, mem_addr, mem_wdata}, 32'd0);
        check("reset_fail_regs", {fail_addr, fail_elem, fail_bg, fail_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        do_run("clean", -1, -1);

        f_en = 1'b1; f_addr = 5; f_bit = 0; f_val = 1'b1;
        do_run("sa1_a5", -1, -1);
        check("sa1_a5_status_direct", 32'(status), 32'd1);
`ifdef MARCH_BIST_DIAG_EN
        check("sa1_a5_diag_direct", {fail_addr, fail_elem, fail_bg, fail_count},
              {4'd5, 3'd1, 2'd0, 16'd5});
`else
        check("sa1_a5_nodiag_direct", {fail_addr, fail_elem, fail_bg, fail_count}, 32'd0);
`endif

        f_en = 1'b0;
        do_run("rerun_repulse", 100, -1);
        do_run("abort", -1, 150);
        do_run("post_reset", -1, -1);

        repeat (3) begin
            f_en   = 1'b1;
            f_addr = $urandom_range(0, DEPTH - 1);
            f_bit  = $urandom_range(0, DW - 1);
            f_val  = 1'($urandom_range(0, 1));
            do_run($sformatf("rand_a%0d_b%0d_v%0d", f_addr, f_bit, f_val), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
